// File: rtl/wb_pkg.sv
// wb_pkg - shared Wishbone definitions for the system bus slice.
//   WB_ADR_W / WB_DAT_W / WB_SEL_W : word-address, data and byte-select widths
//   arb_state_t                     : bus arbiter state encoding
//   idx_width()                     : index width for an N-entry one-hot/index pair
package wb_pkg;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // A single-entry vector still needs a 1-bit index so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick - combinational round-robin priority encoder.
//   req   [N-1:0] : request vector
//   ptr   [W-1:0] : highest-priority position for this scan (0..N-1)
//   valid         : at least one request is asserted
//   idx   [W-1:0] : first asserted request at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Walk the offsets from farthest to nearest so the candidate closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    idx   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_master_arb.sv
// wb_master_arb - round-robin arbiter sharing one Wishbone bus between
// NUM_MASTERS masters (master 0 is the CPU interface). Ownership is held for
// the whole CYC assertion; the grant is registered so the decoder sees the
// same timing as a single master.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   m_cyc_i/m_stb_i/m_we_i [N]        per-master bus controls
//   m_sel_i [4N], m_adr_i [30N], m_dat_i [32N]  per-master slices, master k at slot k
//   m_ack_o [N]                       per-master ACK (only the owner's bit can be set)
//   m_dat_o [32]                      read data broadcast to all masters
//   s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o  bus side towards the decoder
//   s_ack_i, s_dat_i                  bus-side response
//   grant_o [N]                       one-hot current owner, zero when idle
//   timeout_o                         sticky watchdog flag
//
// Optional feature macro: WB_ARB_TIMEOUT_EN enables the unacknowledged-access
// watchdog (limit TIMEOUT_CYCLES). Without it timeout_o is tied low.
module wb_master_arb
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [WB_DAT_W-1:0]             m_dat_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  input  logic                            s_ack_i,
  input  logic [WB_DAT_W-1:0]             s_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            timeout_o
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] mux_idx;
  logic             pick_valid;
  logic             owned;
  logic             owner_cyc;
  logic             stb_block;
  logic             fake_ack;

  rr_pick #(
    .N(NUM_MASTERS),
    .W(IDX_W)
  ) u_pick (
    .req  (m_cyc_i),
    .ptr  (ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign owned     = (state == ARB_OWNED);
  // While idle the data path shows master 0; controls are gated by owned.
  assign mux_idx   = owned ? owner : '0;
  assign owner_cyc = m_cyc_i[mux_idx];
  assign next_ptr  = (int'(pick_idx) >= NUM_MASTERS - 1) ? '0 : IDX_W'(int'(pick_idx) + 1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ARB_IDLE;
      owner   <= '0;
      ptr     <= '0;
      grant_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= ARB_OWNED;
            owner   <= pick_idx;
            ptr     <= next_ptr;
            grant_o <= NUM_MASTERS'(1) << pick_idx;
          end
        end
        ARB_OWNED: begin
          // Ownership ends only when the owner itself drops CYC.
          if (!m_cyc_i[owner]) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             abandoned;
  logic             timeout_q;

  assign fake_ack  = owned & ~abandoned & (to_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign stb_block = abandoned;
  assign timeout_o = timeout_q;

  // Counter is held at zero while idle, so every grant starts from zero.
  // Once the watchdog fires the access is abandoned until the owner releases.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt    <= '0;
      abandoned <= 1'b0;
      timeout_q <= 1'b0;
    end else if (!owned) begin
      to_cnt    <= '0;
      abandoned <= 1'b0;
    end else begin
      if (fake_ack) begin
        abandoned <= 1'b1;
        timeout_q <= 1'b1;
      end
      if (s_ack_i) begin
        to_cnt <= '0;
      end else if (s_stb_o && !fake_ack) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign fake_ack  = 1'b0;
  assign stb_block = 1'b0;
  // No watchdog in this build: constant low, written against TIMEOUT_CYCLES
  // so the parameter stays referenced.
  assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

  // An ACK that coincides with the owner dropping CYC is not forwarded.
  always_comb begin
    s_cyc_o = owned & owner_cyc;
    s_stb_o = owned & owner_cyc & m_stb_i[mux_idx] & ~stb_block;
    s_we_o  = owned & m_we_i[mux_idx];
    s_sel_o = m_sel_i[int'(mux_idx)*WB_SEL_W +: WB_SEL_W];
    s_adr_o = m_adr_i[int'(mux_idx)*WB_ADR_W +: WB_ADR_W];
    s_dat_o = m_dat_i[int'(mux_idx)*WB_DAT_W +: WB_DAT_W];
    m_ack_o = '0;
    if (owned) begin
      m_ack_o[owner] = owner_cyc & ((s_ack_i & ~stb_block) | fake_ack);
    end
    m_dat_o = fake_ack ? '1 : s_dat_i;
  end

endmodule

// File: tb/tb_wb_master_arb.sv
`timescale 1ns/1ps
module tb_wb_master_arb;

  localparam int N = 2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   m_cyc_i, m_stb_i, m_we_i;
  logic [4*N-1:0] m_sel_i;
  logic [30*N-1:0] m_adr_i;
  logic [32*N-1:0] m_dat_i;
  logic [N-1:0]   m_ack_o;
  logic [31:0]    m_dat_o;
  logic           s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]     s_sel_o;
  logic [29:0]    s_adr_o;
  logic [31:0]    s_dat_o;
  logic           s_ack_i;
  logic [31:0]    s_dat_i;
  logic [N-1:0]   grant_o;
  logic           timeout_o;

  always #5 clk_i = ~clk_i;

  wb_master_arb #(
    .NUM_MASTERS(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycle_no   = 0;
  bit check_en   = 1'b0;

  // Reference model: who owns the bus (-1 = nobody) and where the rotation resumes.
  int mdl_owner = -1;
  int mdl_ptr   = 0;
  int mdl_cnt   = 0;
  bit mdl_aband = 1'b0;
  bit mdl_tflag = 1'b0;
  int grant_log[$];
  logic [N-1:0] last_ack = '0;

  int beats[N];
  int gap[N];

  always @(posedge clk_i) cycle_no++;

  function automatic bit mdlPulse();
    return TO_EN && (mdl_owner >= 0) && !mdl_aband && (mdl_cnt == TO);
  endfunction

  function automatic bit mdlStb();
    if (mdl_owner < 0) return 1'b0;
    return m_cyc_i[mdl_owner] && m_stb_i[mdl_owner] && !mdl_aband;
  endfunction

  // Model advance: idle picks the first requester from ptr; an owner keeps the
  // bus until its own CYC drops.
  always @(posedge clk_i or negedge rst_i) begin
    bit pulse, stb_now, found;
    int k;
    if (!rst_i) begin
      mdl_owner = -1; mdl_ptr = 0; mdl_cnt = 0; mdl_aband = 0; mdl_tflag = 0;
    end else if (mdl_owner < 0) begin
      found = 0;
      for (int off = 0; off < N; off++) begin
        k = (mdl_ptr + off) % N;
        if (!found && m_cyc_i[k]) begin
          found = 1;
          mdl_owner = k;
          mdl_ptr   = (k + 1) % N;
          mdl_cnt   = 0;
          mdl_aband = 0;
          grant_log.push_back(k);
        end
      end
    end else begin
      pulse   = mdlPulse();
      stb_now = mdlStb();
      if (pulse) begin mdl_aband = 1; mdl_tflag = 1; end
      if (s_ack_i) mdl_cnt = 0;
      else if (stb_now && !pulse) mdl_cnt++;
      if (!m_cyc_i[mdl_owner]) begin mdl_owner = -1; mdl_aband = 0; end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cycle_no, act, exp);
    end
  endtask

  task automatic compareAll();
    bit owned = (mdl_owner >= 0);
    int o = owned ? mdl_owner : 0;
    bit pulse = mdlPulse();
    logic [N-1:0] exp_ack = '0;
    if (owned && m_cyc_i[o] && ((s_ack_i && !mdl_aband) || pulse)) exp_ack[o] = 1'b1;
    last_ack = exp_ack;
    checkOutput("s_cyc_o", s_cyc_o, owned ? m_cyc_i[o] : 1'b0);
    checkOutput("s_stb_o", s_stb_o, mdlStb());
    checkOutput("s_we_o", s_we_o, owned ? m_we_i[o] : 1'b0);
    checkOutput("m_ack_o", m_ack_o, exp_ack);
    checkOutput("m_dat_o", m_dat_o, pulse ? 32'hFFFF_FFFF : s_dat_i);
    checkOutput("grant_o", grant_o, owned ? (N'(1) << o) : '0);
    checkOutput("timeout_o", timeout_o, mdl_tflag);
    if (owned) begin
      checkOutput("s_sel_o", s_sel_o, m_sel_i[o*4 +: 4]);
      checkOutput("s_adr_o", s_adr_o, m_adr_i[o*30 +: 30]);
      checkOutput("s_dat_o", s_dat_o, m_dat_i[o*32 +: 32]);
    end
  endtask

  always @(negedge clk_i) begin
    #2;
    if (check_en) compareAll();
  end

  task automatic applyStimulus(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                               input logic sack, input logic [31:0] sdat);
    @(negedge clk_i);
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = sack;
    s_dat_i = sdat;
    #3;
  endtask

  task automatic setMaster(input int k, input logic we, input logic [3:0] sel,
                           input logic [29:0] adr, input logic [31:0] dat);
    m_we_i[k]          = we;
    m_sel_i[k*4 +: 4]  = sel;
    m_adr_i[k*30 +: 30] = adr;
    m_dat_i[k*32 +: 32] = dat;
  endtask

  task automatic newPayload(input int k);
    setMaster(k, 1'($urandom_range(0, 1)), 4'($urandom), 30'($urandom), $urandom);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
    for (int k = 0; k < N; k++) begin beats[k] = 0; gap[k] = 0; end
    #3;
    rst_i = 1'b1;
  endtask

  // Reactive masters: each runs a burst of beats, drops CYC, rests, re-requests.
  task automatic runTraffic(input int cycles, input bit fair);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        if (m_cyc_i[k]) begin
          if (last_ack[k]) begin
            beats[k]--;
            if (beats[k] <= 0) begin
              m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
              gap[k] = fair ? 0 : int'($urandom_range(0, 3));
            end else begin
              newPayload(k);
            end
          end else if (!fair && $urandom_range(0, 99) < 3) begin
            m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
            gap[k] = int'($urandom_range(0, 3));
          end
          if (m_cyc_i[k] && !fair) m_stb_i[k] = ($urandom_range(0, 9) < 8);
        end else if (gap[k] > 0) begin
          gap[k]--;
        end else if (fair || $urandom_range(0, 9) < 3) begin
          m_cyc_i[k] = 1'b1; m_stb_i[k] = 1'b1;
          beats[k] = fair ? 1 : int'($urandom_range(1, 4));
          newPayload(k);
        end
      end
      s_ack_i = fair ? 1'b1 : ($urandom_range(0, 9) < 4);
      s_dat_i = $urandom;
      if (!fair && $urandom_range(0, 499) == 0) begin
        rst_i = 1'b0;
        #3;
        rst_i = 1'b1;
      end
    end
  endtask

  initial begin
    int ack_count;
    rst_i = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    check_en = 1'b1;
    repeat (2) @(negedge clk_i);
    #3;
    checkOutput("rst_grant", grant_o, 2'b00);
    checkOutput("rst_s_cyc", s_cyc_o, 1'b0);
    checkOutput("rst_s_stb", s_stb_o, 1'b0);
    checkOutput("rst_m_ack", m_ack_o, 2'b00);
    checkOutput("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b1;

    // Single master read, decoder answers in cycle 3.
    $display("[TB] single master read");
    setMaster(0, 1'b0, 4'hF, 30'h100, 32'h0);
    ack_count = 0;
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    checkOutput("t1_grant_pre", grant_o, 2'b00);
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    checkOutput("t1_grant", grant_o, 2'b01);
    checkOutput("t1_adr", s_adr_o, 30'h100);
    checkOutput("t1_stb", s_stb_o, 1'b1);
    ack_count += m_ack_o[0];
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    ack_count += m_ack_o[0];
    applyStimulus(2'b01, 2'b01, 1'b1, 32'hDEADBEEF);
    checkOutput("t1_ack", m_ack_o, 2'b01);
    checkOutput("t1_rdata", m_dat_o, 32'hDEADBEEF);
    ack_count += m_ack_o[0];
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    checkOutput("t1_grant_hold", grant_o, 2'b01);
    ack_count += m_ack_o[0];
    checkOutput("t1_ack_count", 64'(ack_count), 64'd1);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    checkOutput("t1_grant_idle", grant_o, 2'b00);

    // Contention: master 0 first, one dead cycle, then master 1.
    $display("[TB] contention");
    doReset();
    setMaster(0, 1'b1, 4'h3, 30'h0AA, 32'h1111_0000);
    setMaster(1, 1'b0, 4'hC, 30'h155, 32'h2222_0000);
    applyStimulus(2'b11, 2'b11, 1'b0, 32'h0);
    applyStimulus(2'b11, 2'b11, 1'b0, 32'h0);
    checkOutput("t2_grant0", grant_o, 2'b01);
    checkOutput("t2_adr0", s_adr_o, 30'h0AA);
    checkOutput("t2_we0", s_we_o, 1'b1);
    applyStimulus(2'b11, 2'b11, 1'b1, 32'h5);
    checkOutput("t2_ack0", m_ack_o, 2'b01);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    checkOutput("t2_release_cyc", s_cyc_o, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    checkOutput("t2_dead_cycle", grant_o, 2'b00);
    applyStimulus(2'b10, 2'b10, 1'b1, 32'h6);
    checkOutput("t2_grant1", grant_o, 2'b10);
    checkOutput("t2_adr1", s_adr_o, 30'h155);
    checkOutput("t2_ack1", m_ack_o, 2'b10);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

    // Locked burst by master 1 while master 0 waits.
    $display("[TB] locked burst");
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    applyStimulus(2'b11, 2'b10, 1'b0, 32'h0);
    checkOutput("t3_grant1", grant_o, 2'b10);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(2'b11, 2'b11, 1'b1, $urandom);
      checkOutput("t3_beat_ack", m_ack_o, 2'b10);
      checkOutput("t3_beat_grant", grant_o, 2'b10);
    end
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h7);
    checkOutput("t3_ack_discard", m_ack_o, 2'b00);
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    checkOutput("t3_dead_cycle", grant_o, 2'b00);
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    checkOutput("t3_grant0", grant_o, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

    // Reset in the middle of an owned transfer.
    $display("[TB] reset mid-transfer");
    doReset();
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    checkOutput("t4_grant1", grant_o, 2'b10);
    @(negedge clk_i);
    rst_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    #3;
    checkOutput("t4_rst_cyc", s_cyc_o, 1'b0);
    checkOutput("t4_rst_stb", s_stb_o, 1'b0);
    checkOutput("t4_rst_grant", grant_o, 2'b00);
    checkOutput("t4_rst_ack", m_ack_o, 2'b00);
    rst_i = 1'b1;
    applyStimulus(2'b11, 2'b11, 1'b0, 32'h0);
    checkOutput("t4_first_grant", grant_o, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

    // Fairness under continuous requests.
    $display("[TB] fairness");
    doReset();
    grant_log.delete();
    runTraffic(30, 1'b1);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    checkOutput("t5_log_len", 64'(grant_log.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      checkOutput("t5_grant_seq", 64'(grant_log[i]), 64'(i % 2));
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog fires after TO unacknowledged strobe cycles.
    $display("[TB] watchdog");
    doReset();
    setMaster(0, 1'b0, 4'hF, 30'h200, 32'h0);
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b01, 2'b01, 1'b0, 32'h1234);
      checkOutput("t6_no_ack", m_ack_o, 2'b00);
    end
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h1234);
    checkOutput("t6_fake_ack", m_ack_o, 2'b01);
    checkOutput("t6_fake_data", m_dat_o, 32'hFFFF_FFFF);
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h1234);
    checkOutput("t6_flag", timeout_o, 1'b1);
    checkOutput("t6_stb_forced", s_stb_o, 1'b0);
    checkOutput("t6_late_ack", m_ack_o, 2'b00);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    applyStimulus(2'b01, 2'b01, 1'b0, 32'h0);
    applyStimulus(2'b01, 2'b01, 1'b1, 32'h55);
    checkOutput("t6_normal_ack", m_ack_o, 2'b01);
    checkOutput("t6_flag_sticky", timeout_o, 1'b1);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
`endif

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    doReset();
    runTraffic(3000, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
